// File: rtl/gate_selftest_seq_if.sv
// Self-test bus between gate_selftest_seq and its gate under test / observer.
// master: sequencer side; slave: gate/observer side.
interface gate_selftest_seq_if;
    logic       START;
    logic       F;
    logic       A;
    logic       B;
    logic       BUSY;
    logic       DONE;
    logic       PASS;
    logic [3:0] FAIL_MASK;
    logic [2:0] PASS_CNT;

    modport master (
        input  START, F,
        output A, B, BUSY, DONE, PASS, FAIL_MASK, PASS_CNT
    );

    modport slave (
        output START, F,
        input  A, B, BUSY, DONE, PASS, FAIL_MASK, PASS_CNT
    );
endinterface

// File: rtl/gate_selftest_seq.sv
// On-chip self-test sequencer for a 2-input gate: walks the 4-entry truth table.
// Optional GATE_SELFTEST_STICKY_EN: FAIL_MASK accumulates across runs until reset.
module gate_selftest_seq #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECTED      = 4'b1110
) (
    input  logic                CLK,
    input  logic                RST,
    gate_selftest_seq_if.master bus
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, FINISH} state_t;

    state_t           state, state_d;
    logic [1:0]       idx, idx_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [1:0]       ab_q, ab_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [3:0]       mask_q, mask_d;
    logic [2:0]       pcnt_q, pcnt_d;
    logic             match_c;

    // Unknown F never equals the expected bit, so it is recorded as a mismatch
    assign match_c = (bus.F === EXPECTED[idx]);

    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        ab_d    = ab_q;
        mask_d  = mask_q;
        pcnt_d  = pcnt_q;
        pass_d  = pass_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state)
            IDLE: begin
                ab_d = 2'b00;
                if (bus.START) begin
                    state_d = SETTLE;
                    idx_d   = 2'd0;
                    cnt_d   = CNT_LOAD;
`ifndef GATE_SELFTEST_STICKY_EN
                    mask_d  = 4'b0000;
`endif
                    pcnt_d  = 3'd0;
                    pass_d  = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt == '0) state_d = CHECK;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            CHECK: begin
                if (match_c) pcnt_d      = pcnt_q + 3'd1;
                else         mask_d[idx] = 1'b1;
                if (idx == 2'd3) begin
                    state_d = FINISH;
                    ab_d    = 2'b00;
                    pass_d  = (mask_d == 4'b0000);
                end else begin
                    state_d = SETTLE;
                    idx_d   = idx + 2'd1;
                    ab_d    = idx + 2'd1;
                    cnt_d   = CNT_LOAD;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered copies of the upcoming state
        busy_d = (state_d == SETTLE) || (state_d == CHECK);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            idx    <= 2'd0;
            cnt    <= '0;
            ab_q   <= 2'b00;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            mask_q <= 4'b0000;
            pcnt_q <= 3'd0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            cnt    <= cnt_d;
            ab_q   <= ab_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
            mask_q <= mask_d;
            pcnt_q <= pcnt_d;
        end
    end

    assign bus.A         = ab_q[1];
    assign bus.B         = ab_q[0];
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.PASS      = pass_q;
    assign bus.FAIL_MASK = mask_q;
    assign bus.PASS_CNT  = pcnt_q;
endmodule

// File: tb/tb_gate_selftest_seq.sv
// Self-checking bench for gate_selftest_seq: directed and random gate truth tables
// checked cycle by cycle against a run-level reference model.
module tb_gate_selftest_seq;
    localparam int unsigned SETTLE  = 2;
    localparam logic [3:0]  EXP     = 4'b1110;
    localparam int          VEC_LEN = SETTLE + 1;
    localparam int          RUN_LEN = 4 * VEC_LEN;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] tt;
    logic [3:0] acc_mask;
    int checks = 0;
    int errors = 0;

    gate_selftest_seq_if bus();

    // Gate under test modelled as a truth table indexed by {A,B}
    assign bus.F = tt[{bus.A, bus.B}];

    gate_selftest_seq #(.SETTLE_CYCLES(SETTLE), .EXPECTED(EXP)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".A"}, 32'(bus.A), 0);
        chk({tag, ".B"}, 32'(bus.B), 0);
        chk({tag, ".BUSY"}, 32'(bus.BUSY), 0);
        chk({tag, ".DONE"}, 32'(bus.DONE), 0);
        chk({tag, ".PASS"}, 32'(bus.PASS), 0);
        chk({tag, ".FAIL_MASK"}, 32'(bus.FAIL_MASK), 0);
        chk({tag, ".PASS_CNT"}, 32'(bus.PASS_CNT), 0);
    endtask

    // One run: START sampled at the first edge, cycle c counts from that edge.
    task automatic run(input logic [3:0] gate, input int repulse_c, input int rst_c,
                       input logic hold);
        logic [3:0] run_mask;
        logic [3:0] prior_mask;
        logic [3:0] exp_mask;
        int vec;
        tt = gate;
        run_mask = gate ^ EXP;
`ifdef GATE_SELFTEST_STICKY_EN
        prior_mask = acc_mask;
        exp_mask   = acc_mask | run_mask;
`else
        prior_mask = 4'b0000;
        exp_mask   = run_mask;
`endif
        bus.START = 1'b1;
        step();
        if (!hold) bus.START = 1'b0;
        for (int c = 0; c <= RUN_LEN; c++) begin
            if (c < RUN_LEN) begin
                vec = c / VEC_LEN;
                chk("run.A", 32'(bus.A), 32'(vec[1]));
                chk("run.B", 32'(bus.B), 32'(vec[0]));
                chk("run.BUSY", 32'(bus.BUSY), 1);
                chk("run.DONE", 32'(bus.DONE), 0);
                if (c == 0) begin
                    chk("start.FAIL_MASK", 32'(bus.FAIL_MASK), 32'(prior_mask));
                    chk("start.PASS_CNT", 32'(bus.PASS_CNT), 0);
                    chk("start.PASS", 32'(bus.PASS), 0);
                end
            end else begin
                acc_mask = exp_mask;
                chk("end.DONE", 32'(bus.DONE), 1);
                chk("end.BUSY", 32'(bus.BUSY), 0);
                chk("end.FAIL_MASK", 32'(bus.FAIL_MASK), 32'(exp_mask));
                chk("end.PASS_CNT", 32'(bus.PASS_CNT), 32'(4 - $countones(run_mask)));
                chk("end.PASS", 32'(bus.PASS), 32'(exp_mask == 4'b0000));
            end
            if (c == rst_c) begin
                bus.START = 1'b0;
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk_reset_vals("midrst");
                acc_mask = 4'b0000;
                for (int k = 0; k < RUN_LEN; k++) begin
                    step();
                    chk("midrst.BUSY", 32'(bus.BUSY), 0);
                    chk("midrst.DONE", 32'(bus.DONE), 0);
                end
                return;
            end
            if (c == repulse_c) bus.START = 1'b1;
            else if (c == repulse_c + 1 && !hold) bus.START = 1'b0;
            step();
        end
        // First IDLE cycle after FINISH: results held, START not yet acted on
        chk("idle.BUSY", 32'(bus.BUSY), 0);
        chk("idle.DONE", 32'(bus.DONE), 0);
        chk("idle.A", 32'(bus.A), 0);
        chk("idle.B", 32'(bus.B), 0);
        chk("idle.FAIL_MASK", 32'(bus.FAIL_MASK), 32'(exp_mask));
        chk("idle.PASS", 32'(bus.PASS), 32'(exp_mask == 4'b0000));
    endtask

    initial begin
        logic [3:0] rnd_tt;
        bus.START = 1'b0;
        tt = EXP;
        acc_mask = 4'b0000;

        rst = 1'b1;
        step();
        chk_reset_vals("rst1");
        step();
        chk_reset_vals("rst2");
        rst = 1'b0;
        step();
        chk_reset_vals("post_rst");

        run(4'b1110, -1, -1, 1'b0);                   // good OR gate
        run(4'b0000, -1, -1, 1'b0);                   // stuck-at-0
        run(4'b1000, -1, -1, 1'b0);                   // AND gate substituted
        run(4'b1110, VEC_LEN + 1, -1, 1'b0);          // START re-pulse in vector 1
        run(4'b1110, -1, 2 * VEC_LEN + 1, 1'b0);      // RST in vector 2
        run(4'b1110, -1, -1, 1'b0);                   // fresh run after reset
        run(4'b0000, -1, -1, 1'b0);                   // stuck-at-0 then good gate
        run(4'b1110, -1, -1, 1'b0);
        run(4'b1110, -1, -1, 1'b1);                   // START held across runs
        run(4'b1000, -1, -1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            rnd_tt = 4'($urandom());
            run(rnd_tt, -1, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
